instr_fetch: RTL and testbench

Fetch stage directly downstream of the 10-bit program counter. It turns the counter value into synchronous program-memory reads and drives the counter's enable so the PC advances only when a fetch is issued. Fetched words go out with their PC over a valid/ready handshake to decode. A 2-entry output buffer absorbs decode back-pressure and the 1-cycle memory latency.

---
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: turns the PC into synchronous program-memory reads and hands words plus PC to decode.
// Latency: PC presented in cycle t gives instr_valid in cycle t+2 when the buffer is empty; one word per cycle sustained.
// Backpressure: a 2-entry buffer absorbs stalls; issue (and pc_en) stop when buffered plus in-flight words would exceed 2.
// Optional build macro INSTR_FETCH_STATS_EN adds stall_cnt/stats_clr for counting cycles blocked by a full buffer.
module instr_fetch #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              run,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef INSTR_FETCH_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt
`endif
);

  // Occupancy limit: one word may be in flight while another is held.
  localparam logic [2:0] LP_DEPTH = 3'(BUF_DEPTH);

  // Buffer head (drives decode directly) and the second entry behind it.
  logic [DATA_W-1:0] r_head_dat;
  logic [ADDR_W-1:0] r_head_pc;
  logic              r_head_vld;
  logic [DATA_W-1:0] r_b1_dat;
  logic [ADDR_W-1:0] r_b1_pc;
  logic [1:0]        r_cnt;

  // One outstanding memory read and the PC it was issued for.
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_room;
  logic              w_issue;
  logic [1:0]        w_slot;
  logic [1:0]        w_cnt_nxt;

  // Handshake terms. pop implies r_cnt >= 1, so the occupancy never underflows.
  // Issue is also gated by rst_n so the counter never advances while held in reset.
  always_comb begin
    w_pop     = r_head_vld & instr_ready;
    w_push    = r_inflight & ~flush;
    w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_room    = (w_occ < LP_DEPTH);
    w_issue   = rst_n & run & ~flush & w_room;
    w_slot    = r_cnt - {1'b0, w_pop};
    w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  assign pc_en       = w_issue;
  assign mem_rd      = w_issue;
  assign mem_addr    = rst_n ? pc : '0;
  assign instr       = r_head_dat;
  assign instr_pc    = r_head_pc;
  assign instr_valid = r_head_vld;

  // Track the outstanding read; a flush cycle never issues, so the returning word is forgotten.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= pc;
      end
    end
  end

  // Buffer update: shift entry 1 forward on pop, write the returning word at the tail slot.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_head_vld <= 1'b0;
      r_head_dat <= '0;
      r_head_pc  <= '0;
      r_b1_dat   <= '0;
      r_b1_pc    <= '0;
    end else if (flush) begin
      // Redirect: everything buffered is stale; data regs keep their last value.
      r_cnt      <= 2'd0;
      r_head_vld <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_head_vld <= (w_cnt_nxt != 2'd0);
      if (w_pop && (r_cnt == 2'd2)) begin
        r_head_dat <= r_b1_dat;
        r_head_pc  <= r_b1_pc;
      end
      // With two entries occupied there is never a word in flight, so the slot is 0 or 1.
      if (w_push) begin
        if (w_slot == 2'd0) begin
          r_head_dat <= mem_rdata;
          r_head_pc  <= r_inflight_pc;
        end else begin
          r_b1_dat <= mem_rdata;
          r_b1_pc  <= r_inflight_pc;
        end
      end
    end
  end

`ifdef INSTR_FETCH_STATS_EN
  logic w_stall;

  always_comb begin
    w_stall = run & ~flush & ~w_room;
  end

  // Saturating count of cycles where fetch wanted to run but the buffer was full; clear wins.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (stats_clr) begin
      stall_cnt <= 16'h0000;
    end else if (w_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural up-counter and 1-cycle program memory.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Memory returns {6'h0, addr} so every word identifies the address it came from.
module tb_instr_fetch;

  logic        clk50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [9:0]  pc;
  logic        pc_en;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        ld = 1'b0;
  logic [9:0]  ld_val = 10'h000;
`ifdef INSTR_FETCH_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail = 0;

  always #10 clk50m = ~clk50m;

  instr_fetch dut (
    .clk50m      (clk50m),
    .rst_n       (rst_n),
    .run         (run),
    .flush       (flush),
    .pc          (pc),
    .pc_en       (pc_en),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef INSTR_FETCH_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .stall_cnt   (stall_cnt)
`endif
  );

  // Program counter: load has priority over count-up, wraps naturally at 10 bits.
  always @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) pc <= 10'h000;
    else if (ld) pc <= ld_val;
    else if (pc_en) pc <= pc + 10'h001;
  end

  // Synchronous program memory; garbage when not read.
  always @(posedge clk50m) begin
    mem_rdata <= mem_rd ? {6'h00, mem_addr} : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  // Leaves the bench 1 ns after the edge that starts cycle t0 of the new run.
  task automatic do_reset(input logic r_run, input logic r_rdy);
    rst_n = 1'b0;
    run = r_run;
    instr_ready = r_rdy;
    flush = 1'b0;
    ld = 1'b0;
`ifdef INSTR_FETCH_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk50m);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk50m);
    n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got %b want 0", pc_en); end
    n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
    n_tests++; if (mem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_tests++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr); end
    n_tests++; if (instr_pc !== 10'h000) begin n_fail++; $display("FAIL reset_instr_pc got %h want 000", instr_pc); end
`ifdef INSTR_FETCH_STATS_EN
    n_tests++; if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_stream();
    logic [9:0] exp_pc;
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk50m);
      n_tests++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL stream_pc_en cyc %0d got %b want 1", k, pc_en); end
      n_tests++; if (mem_addr !== 10'(k)) begin n_fail++; $display("FAIL stream_addr cyc %0d got %h want %h", k, mem_addr, 10'(k)); end
      if (k < 2) begin
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid cyc %0d got %b want 0", k, instr_valid); end
      end else begin
        exp_pc = 10'(k - 2);
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b want 1", k, instr_valid); end
        n_tests++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL stream_instr_pc cyc %0d got %h want %h", k, instr_pc, exp_pc); end
        n_tests++; if (instr !== {6'h00, exp_pc}) begin n_fail++; $display("FAIL stream_instr cyc %0d got %h want %h", k, instr, {6'h00, exp_pc}); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    @(negedge clk50m);
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 10'h000) begin n_fail++; $display("FAIL bp_issue0 got rd=%b addr=%h want rd=1 addr=000", mem_rd, mem_addr); end
    tick();
    @(negedge clk50m);
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 10'h001) begin n_fail++; $display("FAIL bp_issue1 got rd=%b addr=%h want rd=1 addr=001", mem_rd, mem_addr); end
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50m);
      n_tests++; if (pc_en !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc %0d got pc_en=%b rd=%b want 0 0", i, pc_en, mem_rd); end
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000) begin n_fail++; $display("FAIL bp_head cyc %0d got v=%b pc=%h want 1 000", i, instr_valid, instr_pc); end
      tick();
    end
    instr_ready = 1'b1;
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000) begin n_fail++; $display("FAIL bp_pop0 got v=%b pc=%h want 1 000", instr_valid, instr_pc); end
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 10'h002) begin n_fail++; $display("FAIL bp_resume got rd=%b addr=%h want 1 002", mem_rd, mem_addr); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h001 || instr !== 16'h0001) begin n_fail++; $display("FAIL bp_pop1 got v=%b pc=%h instr=%h want 1 001 0001", instr_valid, instr_pc, instr); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h002 || instr !== 16'h0002) begin n_fail++; $display("FAIL bp_pop2 got v=%b pc=%h instr=%h want 1 002 0002", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_flush();
    do_reset(1'b1, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    ld = 1'b1;
    ld_val = 10'h200;
    @(negedge clk50m);
    n_tests++; if (mem_rd !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue got rd=%b pc_en=%b want 0 0", mem_rd, pc_en); end
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid got %b want 1", instr_valid); end
    tick();
    flush = 1'b0;
    ld = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cleared got %b want 0", instr_valid); end
    n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 10'h200) begin n_fail++; $display("FAIL flush_reissue got rd=%b addr=%h want 1 200", mem_rd, mem_addr); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got v=%b pc=%h want v=0", instr_valid, instr_pc); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h200 || instr !== 16'h0200) begin n_fail++; $display("FAIL flush_first got v=%b pc=%h instr=%h want 1 200 0200", instr_valid, instr_pc, instr); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h201) begin n_fail++; $display("FAIL flush_second got v=%b pc=%h want 1 201", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [9:0] wexp [4];
    wexp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    do_reset(1'b1, 1'b1);
    flush = 1'b1;
    ld = 1'b1;
    ld_val = 10'h3FE;
    tick();
    flush = 1'b0;
    ld = 1'b0;
    @(negedge clk50m);
    n_tests++; if (mem_addr !== 10'h3FE) begin n_fail++; $display("FAIL wrap_start got %h want 3fe", mem_addr); end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk50m);
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== wexp[k]) begin n_fail++; $display("FAIL wrap_seq %0d got v=%b pc=%h want 1 %h", k, instr_valid, instr_pc, wexp[k]); end
      tick();
    end
  endtask

  task automatic test_run_drop();
    do_reset(1'b1, 1'b1);
    @(negedge clk50m);
    n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rundrop_issue got %b want 1", mem_rd); end
    tick();
    run = 1'b0;
    @(negedge clk50m);
    n_tests++; if (mem_rd !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL rundrop_stop got rd=%b pc_en=%b want 0 0", mem_rd, pc_en); end
    tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 10'h000 || instr !== 16'h0000) begin n_fail++; $display("FAIL rundrop_deliver got v=%b pc=%h instr=%h want 1 000 0000", instr_valid, instr_pc, instr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk50m);
      n_tests++; if (instr_valid !== 1'b0 || mem_rd !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL rundrop_idle %0d got v=%b rd=%b pc_en=%b want 0 0 0", i, instr_valid, mem_rd, pc_en); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b1);
    repeat (4) tick();
    @(negedge clk50m);
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b want 1", instr_valid); end
    tick();
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    n_tests++; if (instr_valid !== 1'b0 || instr_pc !== 10'h000 || instr !== 16'h0000) begin n_fail++; $display("FAIL rstmid_clear got v=%b pc=%h instr=%h want 0 000 0000", instr_valid, instr_pc, instr); end
    n_tests++; if (pc_en !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got pc_en=%b rd=%b want 0 0", pc_en, mem_rd); end
`ifdef INSTR_FETCH_STATS_EN
    n_tests++; if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL rstmid_stall got %0d want 0", stall_cnt); end
`endif
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk50m);
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after %0d got %b want 0", i, instr_valid); end
      tick();
    end
  endtask

`ifdef INSTR_FETCH_STATS_EN
  task automatic test_stats();
    do_reset(1'b1, 1'b0);
    repeat (12) tick();
    @(negedge clk50m);
    n_tests++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stats_count got %0d want 10", stall_cnt); end
    tick();
    stats_clr = 1'b1;
    @(negedge clk50m);
    n_tests++; if (stall_cnt !== 16'd11) begin n_fail++; $display("FAIL stats_pre_clr got %0d want 11", stall_cnt); end
    tick();
    stats_clr = 1'b0;
    @(negedge clk50m);
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clr got %0d want 0", stall_cnt); end
    tick();
    @(negedge clk50m);
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stats_restart got %0d want 1", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_run_drop();
    test_reset_mid();
`ifdef INSTR_FETCH_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
